// File: rtl/rcpu_mem_responder_pkg.sv
// Shared definitions for the RCPU memory responder: FSM encoding, counter sizing
// and the address-window hit test used by every region instance.
package rcpu_mem_responder_pkg;

  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_WAIT = 2'd1,
    RSP_RESP = 2'd2
  } rspState_e;

  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = (1 << CNT_W) - 1;

  // Callers zero-extend both operands to 64 bits, so only the bits above the
  // window index take part in the compare.
  function automatic logic winHit(input logic [63:0] addr, input logic [63:0] base,
                                  input int unsigned depthLog2);
    return ((addr ^ base) >> depthLog2) == 64'd0;
  endfunction

endpackage

// File: rtl/rcpu_mem_array.sv
// Word-wide RAM window: synchronous write port, combinational read port, no reset.
module rcpu_mem_array #(
  parameter int DW         = 16,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DW-1:0]         wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DW-1:0]         rdata
);

  logic [DW-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rcpu_mem_responder.sv
// Memory-side responder for one RCPU RAM region: posted writes, reads answered
// after READ_WAIT wait cycles with a one-cycle memReady/memRead response.
module rcpu_mem_responder
  import rcpu_mem_responder_pkg::*;
#(
  parameter int            AW         = 32,
  parameter int            DW         = 16,
  parameter int            DEPTH_LOG2 = 12,
  parameter logic [AW-1:0] BASE       = '0,
  parameter int            READ_WAIT  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] memAddr,
  input  logic [DW-1:0] memWrite,
  input  logic          memRE,
  input  logic          memWE,
  output logic [DW-1:0] memRead,
  output logic          memReady,
  output logic          oobErr
);

  if (READ_WAIT < 0 || READ_WAIT > MAX_WAIT) begin : gBadWait
    $error("rcpu_mem_responder: READ_WAIT must be in 0..15");
  end

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(READ_WAIT);

  rspState_e       state;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]   latAddr;
  logic [AW-1:0]   rdAddr;
  logic [DW-1:0]   ramData;
  logic [DW-1:0]   respData;
  logic            wrHit;
  logic            wrEn;
  logic            rdHit;
  logic            bypass;
  logic            retarget;
  logic            enterResp;

  assign wrHit = winHit(64'(memAddr), 64'(BASE), DEPTH_LOG2);
  assign wrEn  = memWE && wrHit;

  // In IDLE the request is latched on the same edge that may enter RESP, so
  // the live bus address is the one being resolved.
  assign rdAddr = (state == RSP_IDLE) ? memAddr : latAddr;
  assign rdHit  = winHit(64'(rdAddr), 64'(BASE), DEPTH_LOG2);

  // A write landing on the RESP-entry edge is not yet visible through the
  // array read port, so forward it straight into the response.
  assign bypass   = wrEn && (memAddr[DEPTH_LOG2-1:0] == rdAddr[DEPTH_LOG2-1:0]);
  assign respData = !rdHit ? '0 : (bypass ? memWrite : ramData);

  // The bus shares one address for reads and writes: a write cycle carries the
  // write target, so it never counts as a new read target.
  assign retarget = memRE && !memWE && (memAddr != latAddr);

  always_comb begin
    enterResp = 1'b0;
    case (state)
      RSP_IDLE: enterResp = memRE && (WAIT_LD == '0);
      RSP_WAIT: enterResp = memRE && !retarget && (cnt == 4'd1);
      default:  enterResp = 1'b0;
    endcase
  end

  rcpu_mem_array #(
    .DW        (DW),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) uArray (
    .clk  (clk),
    .we   (wrEn),
    .waddr(memAddr[DEPTH_LOG2-1:0]),
    .wdata(memWrite),
    .raddr(rdAddr[DEPTH_LOG2-1:0]),
    .rdata(ramData)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RSP_IDLE;
      cnt      <= '0;
      latAddr  <= '0;
      memReady <= 1'b0;
      memRead  <= '0;
      oobErr   <= 1'b0;
    end else begin
      memReady <= 1'b0;
      memRead  <= '0;
      oobErr   <= memWE && !wrHit;
      if (enterResp) begin
        memReady <= 1'b1;
        memRead  <= respData;
        if (!rdHit) oobErr <= 1'b1;
      end
      case (state)
        RSP_IDLE: begin
          if (memRE) begin
            latAddr <= memAddr;
            cnt     <= WAIT_LD;
            state   <= (WAIT_LD == '0) ? RSP_RESP : RSP_WAIT;
          end
        end
        RSP_WAIT: begin
          if (!memRE) begin
            state <= RSP_IDLE;
          end else if (retarget) begin
            latAddr <= memAddr;
            cnt     <= WAIT_LD;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= RSP_RESP;
          end
        end
        RSP_RESP: state <= RSP_IDLE;
        default:  state <= RSP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rcpu_mem_responder.sv
// Bench for rcpu_mem_responder: two instances (READ_WAIT=2 and 0) share one bus;
// directed steps plus random traffic checked against a flat RAM model.
module tb_rcpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] memAddr = '0;
  logic [15:0] memWrite = '0;
  logic        memRE = 1'b0;
  logic        memWE = 1'b0;
  logic [15:0] rd2, rd0;
  logic        rdy2, rdy0, oob2, oob0;

  int checks = 0;
  int errors = 0;
  logic [15:0] refMem [4096];
  logic [31:0] pool [8];

  always #5 clk = ~clk;

  rcpu_mem_responder #(.AW(32), .DW(16), .DEPTH_LOG2(12), .BASE(32'h0), .READ_WAIT(2)) dut2 (
    .clk(clk), .rst(rst), .memAddr(memAddr), .memWrite(memWrite), .memRE(memRE),
    .memWE(memWE), .memRead(rd2), .memReady(rdy2), .oobErr(oob2));

  rcpu_mem_responder #(.AW(32), .DW(16), .DEPTH_LOG2(12), .BASE(32'h0), .READ_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .memAddr(memAddr), .memWrite(memWrite), .memRE(memRE),
    .memWE(memWE), .memRead(rd0), .memReady(rdy0), .oobErr(oob0));

  function automatic bit inWin(input logic [31:0] a);
    return a < 32'h0000_1000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [15:0] d);
    memAddr = a; memWrite = d; memWE = 1'b1; memRE = 1'b0;
    step();
    memWE = 1'b0;
    if (inWin(a)) refMem[a[11:0]] = d;
    chk("wr_oob2", 32'(oob2), 32'(!inWin(a)));
    chk("wr_oob0", 32'(oob0), 32'(!inWin(a)));
    chk("wr_rdy", 32'(rdy2 | rdy0), 32'd0);
  endtask

  // One read on the selected instance; optional write injected in cycle wrCyc
  // of the pending read (cycle 0 is the request cycle, so wa must equal a there).
  task automatic rd(input bit sel0, input logic [31:0] a, input int wrCyc,
                    input logic [31:0] wa, input logic [15:0] wd, input bit tail);
    int rw;
    logic [15:0] expD;
    bit oobW;
    rw = sel0 ? 0 : 2;
    expD = '0;
    for (int c = 0; c <= rw; c++) begin
      memRE = 1'b1;
      memWE = (c == wrCyc);
      memAddr = (c == wrCyc) ? wa : a;
      memWrite = wd;
      oobW = 1'b0;
      if (c == wrCyc) begin
        oobW = !inWin(wa);
        if (inWin(wa)) refMem[wa[11:0]] = wd;
      end
      step();
      if (c == rw) expD = inWin(a) ? refMem[a[11:0]] : 16'h0;
      chk("rd_rdy", 32'(sel0 ? rdy0 : rdy2), 32'(c == rw));
      chk("rd_oob", 32'(sel0 ? oob0 : oob2), 32'(oobW || (c == rw && !inWin(a))));
      chk(c == rw ? "rd_data" : "rd_quiet", 32'(sel0 ? rd0 : rd2), 32'(expD));
    end
    memWE = 1'b0;
    if (tail) begin
      memRE = 1'b0;
      step();
      chk("rd_idle_rdy", 32'(sel0 ? rdy0 : rdy2), 32'd0);
      chk("rd_idle_data", 32'(sel0 ? rd0 : rd2), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] a, wa;
    int wc;
    bit s0;

    // reset state
    step(); step();
    chk("rst_rdy", 32'({rdy2, rdy0}), 32'd0);
    chk("rst_data", 32'({rd2, rd0}), 32'd0);
    chk("rst_oob", 32'({oob2, oob0}), 32'd0);
    rst = 1'b1;
    step();
    chk("rel_rdy", 32'({rdy2, rdy0}), 32'd0);
    chk("rel_data", 32'({rd2, rd0}), 32'd0);

    // preload
    wr(32'h10, 16'hBEEF); wr(32'h30, 16'h0001); wr(32'h31, 16'h7777);
    wr(32'h40, 16'h4040); wr(32'h41, 16'h4141); wr(32'h21, 16'h2121);
    wr(32'hFFF, 16'h0FFF);

    // latency on both wait settings
    rd(1'b0, 32'h10, -1, 32'h0, 16'h0, 1'b1);
    rd(1'b1, 32'h10, -1, 32'h0, 16'h0, 1'b1);

    // write then read, then back-to-back reads with memRE held through RESP
    wr(32'h20, 16'h1234);
    rd(1'b0, 32'h20, -1, 32'h0, 16'h0, 1'b0);
    memAddr = 32'h21; memRE = 1'b1;
    step();
    chk("b2b_gap_rdy", 32'(rdy2), 32'd0);
    rd(1'b0, 32'h21, -1, 32'h0, 16'h0, 1'b1);

    // hazards: other index, same index in last WAIT cycle, same-cycle bypass
    rd(1'b0, 32'h30, 2, 32'h31, 16'hBBBB, 1'b1);
    rd(1'b0, 32'h30, 2, 32'h30, 16'hA5A5, 1'b1);
    rd(1'b1, 32'h31, 0, 32'h31, 16'hCAFE, 1'b1);
    rd(1'b0, 32'h40, 0, 32'h40, 16'h4444, 1'b1);

    // out-of-window read and dropped write (aliases index 0x010)
    rd(1'b0, 32'h0001_0000, -1, 32'h0, 16'h0, 1'b1);
    wr(32'h0001_0010, 16'h1111);
    rd(1'b0, 32'h10, -1, 32'h0, 16'h0, 1'b1);

    // abort in WAIT
    memAddr = 32'h41; memRE = 1'b1;
    step();
    chk("abort_rdy0", 32'(rdy2), 32'd0);
    memRE = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_rdy", 32'({rdy2, oob2}), 32'd0);
    end

    // retarget 0x40 -> 0x41 while waiting
    memAddr = 32'h40; memRE = 1'b1;
    step(); chk("rt_c1", 32'(rdy2), 32'd0);
    memAddr = 32'h41;
    step(); chk("rt_c2", 32'(rdy2), 32'd0);
    step(); chk("rt_c3", 32'(rdy2), 32'd0);
    step(); chk("rt_rdy", 32'(rdy2), 32'd1);
    chk("rt_data", 32'(rd2), 32'(refMem[12'h041]));
    memRE = 1'b0;
    step(); chk("rt_idle", 32'(rdy2), 32'd0);

    // async reset during a response
    memAddr = 32'h10; memRE = 1'b1;
    step();
    chk("rstmid_pre", 32'(rdy0), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_rdy", 32'({rdy2, rdy0}), 32'd0);
    chk("rstmid_data", 32'({rd2, rd0}), 32'd0);
    chk("rstmid_oob", 32'({oob2, oob0}), 32'd0);
    memRE = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("rstrel_rdy", 32'({rdy2, rdy0}), 32'd0);
    rd(1'b0, 32'h10, -1, 32'h0, 16'h0, 1'b1);

    // random traffic
    pool = '{32'h10, 32'h20, 32'h21, 32'h30, 32'h31, 32'h40, 32'h41, 32'hFFF};
    for (int it = 0; it < 40; it++) begin
      a = ($urandom_range(0, 7) == 0) ? (32'h0001_0000 | 32'($urandom_range(0, 4095)))
                                      : pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 2) == 0) begin
        wr(a, 16'($urandom));
      end else begin
        s0 = 1'($urandom_range(0, 1));
        wc = $urandom_range(0, 3);
        wa = (wc == 0) ? a : pool[$urandom_range(0, 7)];
        rd(s0, a, wc, wa, 16'($urandom), 1'b1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
